// File: rtl/regfile.sv
// General-purpose register file with two combinational read ports, one write port and same-cycle
// write-to-read bypass. After reset an init engine zeroes the array before ready_o is raised.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              ready_o
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                ready_q, ready_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_wen;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ready_d   = ready_q;
        mem_wen   = 1'b0;
        mem_waddr = waddr_i;
        mem_wdata = wdata_i;
        case (state_q)
            INIT: begin
                // Clearing owns the write port; write-back requests are dropped here.
                mem_wen   = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d   = RUN;
                    ready_d   = 1'b1;
                    clr_ptr_d = clr_ptr_q;
                end
            end
            RUN: begin
                mem_wen = we_i && (waddr_i != '0);
            end
            default: begin
                state_d = INIT;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= INIT;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wen) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic              en,
        input logic [ADDR_W-1:0] addr
    );
        logic [DATA_W-1:0] val;
        val = '0;
        if (rst && ready_q && en && (addr != '0)) begin
            if (we_i && (waddr_i == addr)) begin
                val = wdata_i;
            end else begin
                val = mem_q[addr];
            end
        end
        return val;
    endfunction

    always_comb begin
        rdata1_o = read_port(re1_i, raddr1_i);
        rdata2_o = read_port(re2_i, raddr2_i);
    end

    assign ready_o = ready_q;

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the OpenMIPS pipeline: the responder to the decode stage's two register read requests and the sink of the write-back stage's single write port. The storage array is cleared in hardware after reset by a self-sequencing init engine. Reads are combinational so decode receives operands in the same cycle it presents addresses. Same-cycle write-to-read forwarding removes the write-back/decode hazard.

## Interface
- `DATA_W`, 32: register width (`RegBus`).
- `ADDR_W`, 5: register address width (`RegAddrBus`).
- `DEPTH`, 32: number of registers; equals 2^`ADDR_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `we_i` in 1: write enable from write-back.
- `waddr_i` in `ADDR_W`: write address.
- `wdata_i` in `DATA_W`: write data.
- `re1_i` in 1: read port 1 enable, driven by decode's `reg1_read_o`.
- `raddr1_i` in `ADDR_W`: read port 1 address.
- `rdata1_o` out `DATA_W`: read port 1 data, combinational.
- `re2_i` in 1: read port 2 enable, driven by decode's `reg2_read_o`.
- `raddr2_i` in `ADDR_W`: read port 2 address.
- `rdata2_o` out `DATA_W`: read port 2 data, combinational.
- `ready_o` out 1: array initialised; reads and writes are honoured.

## Operation
- FSM states: `INIT` and `RUN`.
- Reset (`rst`=0) forces `INIT`, clear pointer `clr_ptr`=0 and `ready_o`=0. Array contents are not reset directly.
- `INIT` behaviour:
  - Each rising edge writes 0 to `mem[clr_ptr]`, then increments `clr_ptr`.
  - On the edge that clears entry `DEPTH-1`, the FSM moves to `RUN` and `ready_o` registers to 1.
  - `we_i` is ignored; the write is dropped, not queued.
  - Both read outputs are 0.
- `RUN` behaviour:
  - `RUN` is left only by reset. Reset asserted mid-operation restarts the full `INIT` sequence.
  - Write: on a rising edge with `we_i`=1 and `waddr_i`≠0, `mem[waddr_i]` takes `wdata_i`. Writes to address 0 are discarded.
- Read port n (identical logic on both ports), evaluated in priority order:
  1. `rst`=0 or `ready_o`=0: output 0.
  2. `ren_i`=0: output 0.
  3. `raddrn_i`=0: output 0. Register 0 is hardwired zero.
  4. `we_i`=1 and `waddr_i`==`raddrn_i`: output `wdata_i` (bypass).
  5. Otherwise: output `mem[raddrn_i]`.
- Both ports may address the same register. Both may hit the bypass in the same cycle; both then return `wdata_i`.
- No arithmetic. `clr_ptr` is `ADDR_W` bits wide. The terminal test is `clr_ptr`==`DEPTH-1`, so the pointer never wraps to re-enter clearing.

## Timing
- Output values at reset: `ready_o`=0, `rdata1_o`=0, `rdata2_o`=0.
- `ready_o` rises on the `DEPTH`th rising edge after `rst` deasserts: edge 32 with default parameters.
- Write latency: 1 edge. Data is visible from the array on the cycle after the write edge, and through the bypass in the write cycle itself.
- Read latency: 0 cycles, combinational from address, enable and write-port inputs.
- No back-pressure. Decode and write-back must gate on `ready_o`; the pipeline stalls while `ready_o`=0.

## Test plan
- Reset/init:
  - Stimulus: pulse `rst` low, release, drive `we_i`=1, `waddr_i`=5, `wdata_i`=32'hDEADBEEF on cycle 3, and hold `re1_i`=1, `raddr1_i`=5.
  - Required response: `rdata1_o`=0 throughout `INIT`; `ready_o` rises exactly at edge 32; `rdata1_o`=0 afterwards, proving the write was dropped.
- Basic write/read:
  - Stimulus: in `RUN`, write 32'h0000_1234 to r7.
  - Required response: next cycle, `re2_i`=1, `raddr2_i`=7 gives `rdata2_o`=32'h0000_1234; with `re2_i`=0, `rdata2_o`=0.
- r0 hardwired:
  - Stimulus: write 32'hFFFF_FFFF to r0; in the same cycle and the next, read r0 on both ports.
  - Required response: both ports return 0 in both cycles.
- Bypass:
  - Stimulus: r9 holds 32'h1; in one cycle, write 32'hABCD to r9 while both ports read r9.
  - Required response: both ports return 32'hABCD in that cycle and 32'hABCD from the array in the next cycle.
- Reset mid-operation:
  - Stimulus: in `RUN` with r3=32'h55, assert `rst` low for 1 cycle, then read r3 after `ready_o` rises again.
  - Required response: `ready_o` drops immediately (asynchronous); r3 reads 0.
- Dual independent reads:
  - Stimulus: r1=32'h11, r2=32'h22; read port 1 at address 2 and port 2 at address 1 in the same cycle.
  - Required response: `rdata1_o`=32'h22, `rdata2_o`=32'h11.
